// File: rtl/hex_disp_pkg.sv
// Shared constants and state type for the multiplexed HEX display scheduler.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 8;
  localparam int unsigned SEG_W          = 7;
  localparam int unsigned NIBBLE_W       = 4;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/hex_refresh_tick.sv
// Free-running divider that pulses tick on the last cycle of every TICK_DIV period.
module hex_refresh_tick #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Arbitrates host loads and periodic snapshots, then scans the chosen word
// through the shared external decoder one nibble per cycle, MSB digit first.
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
  output logic                          load_ready,
  input  logic                          blank_lz,
  input  logic                          enable,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] live_data,
  output logic [NIBBLE_W-1:0]           dec_nibble,
  input  logic [SEG_W-1:0]              dec_seg,
  output logic [SEG_W*NUM_DIGITS-1:0]   hex_out,
  output logic                          frame_done
);

  localparam int unsigned W     = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t           state;
  logic [W-1:0]     shadow;
  logic             blank_q;
  logic             lz_active;
  logic             pending;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             take_load;
  logic             take_snap;
  logic [W-1:0]     word;
  logic [SEG_W-1:0] cap_seg;

  hex_refresh_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick)
  );

  assign load_ready = (state == IDLE);
  assign take_load  = load_ready && load_valid;
  assign take_snap  = load_ready && !load_valid && enable && (pending || tick);
  assign word       = take_load ? load_data : live_data;
  assign idx_nxt    = idx - 1'b1;

  // Leading zeros blank only until the first nonzero nibble; digit 0 always shows.
  assign cap_seg = (blank_q && lz_active && (dec_nibble == '0) && (idx != '0))
                   ? SEG_BLANK : dec_seg;

  // A tick that loses arbitration to the host, or lands mid-scan, is remembered once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!enable || take_snap) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      blank_q    <= 1'b0;
      lz_active  <= 1'b0;
      idx        <= '0;
      dec_nibble <= '0;
      hex_out    <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_load || take_snap) begin
            shadow     <= word;
            blank_q    <= blank_lz;
            lz_active  <= 1'b1;
            idx        <= IDX_W'(NUM_DIGITS - 1);
            dec_nibble <= word[W-1 -: NIBBLE_W];
            state      <= SCAN;
          end
        end
        SCAN: begin
          hex_out[idx*SEG_W +: SEG_W] <= cap_seg;
          if (dec_nibble != '0) begin
            lz_active <= 1'b0;
          end
          if (idx == '0) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            idx        <= idx_nxt;
            dec_nibble <= shadow[idx_nxt*NIBBLE_W +: NIBBLE_W];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench: frame-level reference model plus directed literal checks.
module tb_hex_display_scheduler;

  localparam int ND = 8;
  localparam int TD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] live_data = '0;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [55:0] hex_out;
  logic        frame_done;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  bit         m_busy;
  int         m_pos;
  logic [31:0] m_word;
  logic [6:0] m_frame [ND];
  logic [6:0] m_hex   [ND];
  bit         m_fd;
  int         m_cnt;
  bit         m_pend;
  logic [3:0] m_nib;

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // the shared decoder lives outside the scheduler
  assign dec_seg = seg7(dec_nibble);

  hex_display_scheduler #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .blank_lz  (blank_lz),
    .enable    (enable),
    .live_data (live_data),
    .dec_nibble(dec_nibble),
    .dec_seg   (dec_seg),
    .hex_out   (hex_out),
    .frame_done(frame_done)
  );

  function automatic logic [55:0] model_hex();
    logic [55:0] r;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = m_hex[i];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fd = 0; m_cnt = 0; m_pend = 0; m_nib = '0; m_pos = 0;
    for (int i = 0; i < ND; i++) m_hex[i] = 7'h7F;
  endtask

  task automatic model_start(input logic [31:0] w, input logic bl);
    m_busy = 1; m_pos = ND - 1; m_word = w; m_nib = w[31:28];
    for (int d = 0; d < ND; d++)
      m_frame[d] = (bl && d != 0 && (w >> (4*d)) == 0) ? 7'h7F : seg7(w[4*d +: 4]);
  endtask

  // advance the model across one rising edge using the inputs now applied
  task automatic model_advance();
    bit tick, snap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick  = enable && (m_cnt == TD - 1);
    m_cnt = enable ? (m_cnt + 1) % TD : 0;
    snap  = !m_busy && !load_valid && enable && (m_pend || tick);
    m_fd  = 0;
    if (m_busy) begin
      m_hex[m_pos] = m_frame[m_pos];
      if (m_pos == 0) begin
        m_busy = 0; m_fd = 1;
      end else begin
        m_pos--;
        m_nib = m_word[4*m_pos +: 4];
      end
    end else if (load_valid) begin
      model_start(load_data, blank_lz);
    end else if (snap) begin
      model_start(live_data, blank_lz);
    end
    if (!enable || snap) m_pend = 0;
    else if (tick)       m_pend = 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("hex_out",    {8'h0, hex_out},   {8'h0, model_hex()});
    check("load_ready", 64'(load_ready),   64'(!m_busy));
    check("frame_done", 64'(frame_done),   64'(m_fd));
    check("dec_nibble", 64'(dec_nibble),   64'(m_nib));
  endtask

  task automatic step();
    model_advance();
    @(negedge clk);
    compare_all();
  endtask

  // host load with enable low; checks latency and final digits against literals
  task automatic do_frame(input string name, input logic [31:0] w, input logic bl,
                          input logic [55:0] exp_hex);
    int fd_at;
    load_data = w; blank_lz = bl; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check({name, "_ready_low"}, 64'(load_ready), 64'd0);
    fd_at = -1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (frame_done && fd_at < 0) fd_at = k;
    end
    check({name, "_fd_cycle"}, 64'(fd_at), 64'd8);
    check({name, "_digits"}, {8'h0, hex_out}, {8'h0, exp_hex});
  endtask

  initial begin
    int fd1, fd2, n, cnt_fd;
    bit acc;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_hex", {8'h0, hex_out}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
    check("reset_ready", 64'(load_ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_hex", {8'h0, hex_out}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});

    do_frame("plain", 32'h0123_89AB, 1'b0,
             {7'h40, 7'h79, 7'h24, 7'h30, 7'h00, 7'h10, 7'h08, 7'h03});
    do_frame("blank_zero", 32'h0000_0000, 1'b1, {{7{7'h7F}}, 7'h40});
    do_frame("blank_mid", 32'h00F0_0005, 1'b1,
             {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});

    // periodic snapshots
    blank_lz = 1'b0; live_data = 32'hDEAD_BEEF; enable = 1'b1;
    fd1 = -1; fd2 = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (frame_done) begin
        if (fd1 < 0) fd1 = k;
        else if (fd2 < 0) fd2 = k;
      end
    end
    check("snap_period", 64'(fd2 - fd1), 64'd16);
    check("snap_digits", {8'h0, hex_out},
          {8'h0, 7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});

    // host and tick collide in an idle cycle
    n = 0;
    while (!(m_cnt == TD - 1 && !m_busy) && n < 64) begin
      step(); n++;
    end
    check("collide_found", 64'(n < 64), 64'd1);
    live_data = 32'h1111_2222; load_data = 32'h3333_4444; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    n = 0;
    while (!frame_done && n < 20) begin
      step(); n++;
    end
    check("collide_fd_seen", 64'(frame_done), 64'd1);
    check("collide_host_first", {8'h0, hex_out},
          {8'h0, 7'h30, 7'h30, 7'h30, 7'h30, 7'h19, 7'h19, 7'h19, 7'h19});
    step();
    check("collide_snap_start", 64'(load_ready), 64'd0);
    repeat (10) step();

    // reset in the middle of a frame
    enable = 1'b0;
    repeat (20) step();
    load_data = 32'h89AB_CDEF; blank_lz = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_hex", {8'h0, hex_out}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
    check("midreset_ready", 64'(load_ready), 64'd1);
    repeat (2) step();
    rst_n = 1'b1;
    cnt_fd = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (frame_done) cnt_fd++;
    end
    check("midreset_no_fd", 64'(cnt_fd), 64'd0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (!load_valid && $urandom_range(0, 9) == 0) begin
        load_valid = 1'b1;
        load_data  = $urandom >> $urandom_range(0, 32);
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      blank_lz  = 1'($urandom_range(0, 1));
      live_data = $urandom >> $urandom_range(0, 32);
      rst_n     = ($urandom_range(0, 599) != 0);
      acc = load_valid && load_ready && rst_n;
      step();
      if (acc) load_valid = 1'b0;
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
